// File: rtl/his_acq_sequencer_pkg.sv
// Shared definitions for the two-pass dToF histogram acquisition sequencer.
// Holds the default code/address widths and the sequencer state encoding.
package his_acq_sequencer_pkg;

  localparam int NP_DEF = 8;
  localparam int NB_DEF = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR_C = 3'd1,
    S_ACQ_C = 3'd2,
    S_RD_C  = 3'd3,
    S_CLR_F = 3'd4,
    S_ACQ_F = 3'd5,
    S_RD_F  = 3'd6,
    S_DONE  = 3'd7
  } state_t;

  // States belonging to the fine pass; DONE still reports the fine histogram.
  function automatic logic is_fine(input state_t s);
    return (s == S_CLR_F) || (s == S_ACQ_F) || (s == S_RD_F) || (s == S_DONE);
  endfunction

endpackage

// File: rtl/his_acq_sequencer_win_calc.sv
// Fine-window arithmetic: centres a 2^NB-bin window on the coarse peak and
// maps a TDC code into that window.
module win_calc
  import his_acq_sequencer_pkg::*;
#(
  parameter int NP = NP_DEF,
  parameter int NB = NB_DEF
) (
  input  logic [NB-1:0] peak_bin,
  input  logic [NP-1:0] tdc_code,
  input  logic [NP-1:0] win_base,
  output logic [NP-1:0] win_base_new,
  output logic [NB-1:0] fine_addr,
  output logic          in_win
);

  localparam int W = NP + 2;
  localparam logic [W-1:0] HALF_BIN = W'(1) << (NP - NB - 1);
  localparam logic [W-1:0] HALF_WIN = W'(1) << (NB - 1);
  localparam logic [W-1:0] MAX_BASE = (W'(1) << NP) - (W'(1) << NB);

  logic [W-1:0] centre;
  logic [NP-1:0] off;

  // Two guard bits let the window start be compared before clamping.
  always_comb begin
    centre = (W'(peak_bin) << (NP - NB)) + HALF_BIN;
    if (centre < HALF_WIN) begin
      win_base_new = '0;
    end else if ((centre - HALF_WIN) > MAX_BASE) begin
      win_base_new = NP'(MAX_BASE);
    end else begin
      win_base_new = NP'(centre - HALF_WIN);
    end
  end

  assign off       = tdc_code - win_base;
  assign fine_addr = off[NB-1:0];
  assign in_win    = (off[NP-1:NB] == '0);

endmodule

// File: rtl/his_acq_sequencer.sv
// Two-pass (coarse then fine) histogram acquisition sequencer between the TDC
// front end and the histogram builder / peak detector.
module his_acq_sequencer
  import his_acq_sequencer_pkg::*;
#(
  parameter int NP    = NP_DEF,
  parameter int NB    = NB_DEF,
  parameter int ACQ_W = 10,
  parameter int N_ACQ = 512,
  parameter int TMO   = 255
) (
  input  logic          clk,
  input  logic          res,
  input  logic          start,
  input  logic          laser_sync,
  input  logic          tdc_valid,
  input  logic [NP-1:0] tdc_code,
  input  logic          peak_valid,
  input  logic [NB-1:0] peak_bin,
  output logic          his_clr,
  output logic          his_wr_en,
  output logic [NB-1:0] his_addr,
  output logic          his_num,
  output logic          rd_req,
  output logic          busy,
  output logic          result_valid,
  output logic [NP-1:0] dist_code,
  output logic [NP-1:0] win_base,
  output logic [7:0]    drop_cnt,
  output logic          err_tmo
);

  localparam int TW = $clog2(TMO + 1);
  localparam logic [NB-1:0]    CLR_LAST = '1;
  localparam logic [ACQ_W-1:0] ACQ_LAST = ACQ_W'(N_ACQ - 1);
  localparam logic [TW-1:0]    TMO_LAST = TW'(TMO - 1);

  state_t state, state_nxt;

  logic [NB-1:0]    clr_cnt;
  logic [ACQ_W-1:0] acq_cnt;
  logic [TW-1:0]    tmo_cnt;
  logic [NB-1:0]    hit_addr;
  logic             his_num_q;

  logic [NP-1:0] win_base_new;
  logic [NB-1:0] fine_addr;
  logic          in_win;

  logic in_clr, in_acq, in_rd;

  win_calc #(
    .NP(NP),
    .NB(NB)
  ) u_win_calc (
    .peak_bin    (peak_bin),
    .tdc_code    (tdc_code),
    .win_base    (win_base),
    .win_base_new(win_base_new),
    .fine_addr   (fine_addr),
    .in_win      (in_win)
  );

  assign in_clr = (state == S_CLR_C) || (state == S_CLR_F);
  assign in_acq = (state == S_ACQ_C) || (state == S_ACQ_F);
  assign in_rd  = (state == S_RD_C)  || (state == S_RD_F);

  always_comb begin
    state_nxt    = state;
    his_clr      = 1'b0;
    rd_req       = 1'b0;
    result_valid = 1'b0;
    his_num      = his_num_q;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_CLR_C;
      end
      S_CLR_C, S_CLR_F: begin
        his_clr = 1'b1;
        if (clr_cnt == CLR_LAST) state_nxt = (state == S_CLR_C) ? S_ACQ_C : S_ACQ_F;
      end
      S_ACQ_C, S_ACQ_F: begin
        if (laser_sync && (acq_cnt == ACQ_LAST))
          state_nxt = (state == S_ACQ_C) ? S_RD_C : S_RD_F;
      end
      // tmo_cnt is zero only in the first read cycle, which gives the one-shot request.
      S_RD_C, S_RD_F: begin
        rd_req = (tmo_cnt == '0);
        if (peak_valid) state_nxt = (state == S_RD_C) ? S_CLR_F : S_DONE;
        else if (tmo_cnt == TMO_LAST) state_nxt = S_IDLE;
      end
      S_DONE: begin
        result_valid = 1'b1;
        state_nxt    = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (state != S_IDLE) his_num = is_fine(state);
  end

  assign busy     = (state != S_IDLE);
  assign his_addr = his_clr ? clr_cnt : hit_addr;

  always_ff @(posedge clk) begin
    if (!res) begin
      state     <= S_IDLE;
      clr_cnt   <= '0;
      acq_cnt   <= '0;
      tmo_cnt   <= '0;
      hit_addr  <= '0;
      his_wr_en <= 1'b0;
      his_num_q <= 1'b0;
      drop_cnt  <= '0;
      err_tmo   <= 1'b0;
      win_base  <= '0;
      dist_code <= '0;
    end else begin
      state     <= state_nxt;
      his_num_q <= his_num;
      clr_cnt   <= in_clr ? clr_cnt + 1'b1 : '0;
      tmo_cnt   <= in_rd ? tmo_cnt + 1'b1 : '0;

      if (!in_acq) acq_cnt <= '0;
      else if (laser_sync) acq_cnt <= acq_cnt + 1'b1;

      // Hits are registered so the write reaches the builder one cycle later.
      his_wr_en <= 1'b0;
      if ((state == S_ACQ_C) && tdc_valid) begin
        his_wr_en <= 1'b1;
        hit_addr  <= tdc_code[NP-1:NP-NB];
      end
      if ((state == S_ACQ_F) && tdc_valid) begin
        if (in_win) begin
          his_wr_en <= 1'b1;
          hit_addr  <= fine_addr;
        end else if (drop_cnt != 8'hFF) begin
          drop_cnt <= drop_cnt + 8'd1;
        end
      end

      if ((state == S_IDLE) && start) begin
        drop_cnt <= '0;
        err_tmo  <= 1'b0;
      end

      if ((state == S_RD_C) && peak_valid) win_base <= win_base_new;
      if ((state == S_RD_F) && peak_valid) dist_code <= win_base + NP'(peak_bin);
      if (in_rd && !peak_valid && (tmo_cnt == TMO_LAST)) err_tmo <= 1'b1;
    end
  end

endmodule
